// File: rtl/servo_ramp.sv
// servo_ramp: single-channel hobby-servo PWM driver.
// An internal position slews toward the clamped commanded position by STEP
// counts on each rising edge of the slow tick SLK. The PWM high time for a
// frame is latched at the frame start (COUNT == 0) as MIN_PULSE + position.
// FLAG reports that the position has reached the clamped target.
module servo_ramp #(
  parameter int unsigned MIN_PULSE = 50000,
  parameter int unsigned MAX_POS   = 200000,
  parameter int unsigned INIT_POS  = 0,
  parameter int unsigned STEP      = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        slk_i,
  input  logic [27:0] count_i,
  input  logic [19:0] desired_i,
  output logic        pwm_o,
  output logic        flag_o
);

  localparam logic [19:0] MAX_POS_C   = 20'(MAX_POS);
  localparam logic [19:0] INIT_POS_C  = 20'(INIT_POS);
  localparam logic [19:0] STEP_C      = 20'(STEP);
  localparam logic [20:0] MIN_PULSE_C = 21'(MIN_PULSE);
  localparam logic [20:0] INIT_WIDTH_C = MIN_PULSE_C + {1'b0, INIT_POS_C};

  // One slew step toward the target, limited so it can never overshoot.
  function automatic logic [19:0] slew_pos(input logic [19:0] pos,
                                           input logic [19:0] tgt);
    logic [19:0] gap;
    logic [19:0] res;
    gap = 20'd0;
    res = pos;
    if (pos < tgt) begin
      gap = tgt - pos;
      res = (gap < STEP_C) ? tgt : (pos + STEP_C);
    end else if (pos > tgt) begin
      gap = pos - tgt;
      res = (gap < STEP_C) ? tgt : (pos - STEP_C);
    end else begin
      res = pos;
    end
    return res;
  endfunction

  logic        slk_q;
  logic        slk_d;
  logic [19:0] pos_q;
  logic [19:0] pos_d;
  logic [20:0] width_q;
  logic [20:0] width_d;
  logic        pwm_q;
  logic        pwm_d;
  logic        flag_q;
  logic        flag_d;
  logic        tick_s;
  logic [19:0] tgt_s;

  // Next-state logic: tick detect, target clamp, slew, width latch, outputs.
  always_comb begin
    tgt_s   = (desired_i > MAX_POS_C) ? MAX_POS_C : desired_i;
    tick_s  = slk_i & ~slk_q;
    slk_d   = slk_i;
    pos_d   = pos_q;
    width_d = width_q;
    if (tick_s) begin
      pos_d = slew_pos(pos_q, tgt_s);
    end else begin
      pos_d = pos_q;
    end
    // Frame start latches the pre-update position so the width is frame-stable.
    if (count_i == 28'd0) begin
      width_d = MIN_PULSE_C + {1'b0, pos_q};
    end else begin
      width_d = width_q;
    end
    pwm_d  = (count_i < {7'd0, width_q});
    flag_d = (pos_q == tgt_s);
  end

  // State and registered outputs; reset cuts off any pulse immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slk_q   <= 1'b0;
      pos_q   <= INIT_POS_C;
      width_q <= INIT_WIDTH_C;
      pwm_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      slk_q   <= slk_d;
      pos_q   <= pos_d;
      width_q <= width_d;
      pwm_q   <= pwm_d;
      flag_q  <= flag_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign flag_o = flag_q;

endmodule

// File: tb/tb_servo_ramp.sv
// Testbench for servo_ramp with a scaled-down frame (64 cycles) and small
// position range so full ramps fit in a short run. A behavioural model tracks
// position/width/outputs; pulse lengths are measured and checked per frame.
module tb_servo_ramp;

  localparam int MIN_P = 8;
  localparam int MAXP  = 40;
  localparam int INITP = 3;
  localparam int STEPP = 2;
  localparam int FRAME = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slk = 1'b0;
  logic [27:0] count = 28'd0;
  logic [19:0] desired = 20'd0;
  logic        pwm;
  logic        flag;

  int errors = 0;
  int checks = 0;
  int cnt = 0;

  int   m_pos, m_width;
  logic m_pwm, m_flag, m_slk;
  int   hi_len = 0, frame_w = 0, last_len = -1;
  bit   frame_ok = 0;

  servo_ramp #(.MIN_PULSE(MIN_P), .MAX_POS(MAXP), .INIT_POS(INITP), .STEP(STEPP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .slk_i(slk), .count_i(count),
    .desired_i(desired), .pwm_o(pwm), .flag_o(flag)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos = INITP; m_width = MIN_P + INITP;
    m_pwm = 1'b0; m_flag = 1'b0; m_slk = 1'b0;
    frame_ok = 0; hi_len = 0;
  endtask

  // One clock: drive inputs, advance model, compare outputs, measure pulses.
  task automatic cycle(input bit s, input int d);
    int tgt, npos, cdrv;
    cdrv = cnt;
    slk = s; desired = 20'(d); count = 28'(cdrv);
    if (cdrv == 0) begin
      if (frame_ok) begin
        last_len = hi_len;
        checks++;
        if (hi_len !== frame_w)
          $display("FAIL pulse_len: got %0d cycles, expected %0d", hi_len, frame_w);
        if (hi_len !== frame_w) errors++;
      end
      frame_ok = (rst_n === 1'b1);
      hi_len = 0;
      frame_w = MIN_P + m_pos;
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      tgt = (d > MAXP) ? MAXP : d;
      npos = m_pos;
      if (s && !m_slk) begin
        if (m_pos < tgt) npos = m_pos + (((tgt - m_pos) < STEPP) ? (tgt - m_pos) : STEPP);
        else if (m_pos > tgt) npos = m_pos - (((m_pos - tgt) < STEPP) ? (m_pos - tgt) : STEPP);
      end
      m_pwm = (cdrv < m_width);
      m_flag = (m_pos == tgt);
      if (cdrv == 0) m_width = MIN_P + m_pos;
      m_pos = npos;
      m_slk = s;
    end
    cnt = (cdrv + 1) % FRAME;
    #1;
    checks++;
    if (pwm !== m_pwm) begin
      errors++;
      $display("FAIL pwm: t=%0t count=%0d got %b expected %b", $time, cdrv, pwm, m_pwm);
    end
    checks++;
    if (flag !== m_flag) begin
      errors++;
      $display("FAIL flag: t=%0t got %b expected %b", $time, flag, m_flag);
    end
    if (pwm === 1'b1) hi_len++;
  endtask

  // Idle with SLK low until the frame that starts after now has completed.
  task automatic wait_two_frames(input int d);
    int seen;
    seen = 0;
    last_len = -1;
    while (seen < 2) begin
      if (cnt == 0) seen++;
      cycle(1'b0, d);
    end
  endtask

  // Run with SLK = COUNT[2] until FLAG rises; expiry counts as a failure.
  task automatic run_until_flag(input int d, input int budget);
    int n;
    n = 0;
    do begin
      cycle(cnt[2], d);
      n++;
    end while (flag !== 1'b1 && n < budget);
    checks++;
    if (flag !== 1'b1) begin
      errors++;
      $display("FAIL settle_timeout: flag=%b after %0d cycles, expected 1", flag, n);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (pwm !== 1'b0 || flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pwm=%b flag=%b expected 0 0", pwm, flag);
    end
    model_reset();
    cycle(1'b0, INITP);
    cycle(1'b0, INITP);
    rst_n = 1'b1;
    cycle(1'b0, INITP);
    cycle(1'b0, INITP);
    checks++;
    if (flag !== 1'b1) begin
      errors++;
      $display("FAIL reset_flag: got %b expected 1", flag);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 2 * FRAME; i++) cycle(cnt[2], INITP);
    wait_two_frames(INITP);
    checks++;
    if (last_len !== MIN_P + INITP) begin
      errors++;
      $display("FAIL idle_width: got %0d expected %0d", last_len, MIN_P + INITP);
    end
  endtask

  task automatic test_clamp_and_reverse();
    int r;
    run_until_flag(1000, 2000);
    wait_two_frames(1000);
    checks++;
    if (last_len !== MIN_P + MAXP) begin
      errors++;
      $display("FAIL clamp_width: got %0d expected %0d", last_len, MIN_P + MAXP);
    end
    r = $urandom_range(0, MAXP - 1);
    cycle(1'b0, r);
    checks++;
    if (flag !== 1'b0) begin
      errors++;
      $display("FAIL flag_drop: got %b expected 0", flag);
    end
    run_until_flag(r, 2000);
    wait_two_frames(r);
    checks++;
    if (last_len !== MIN_P + r) begin
      errors++;
      $display("FAIL reverse_width: got %0d expected %0d", last_len, MIN_P + r);
    end
  endtask

  task automatic test_random_targets();
    int d, e;
    for (int k = 0; k < 4; k++) begin
      d = $urandom_range(0, MAXP + 20);
      e = (d > MAXP) ? MAXP : d;
      run_until_flag(d, 2000);
      wait_two_frames(d);
      checks++;
      if (last_len !== MIN_P + e) begin
        errors++;
        $display("FAIL target_width: desired=%0d got %0d expected %0d", d, last_len, MIN_P + e);
      end
    end
  endtask

  task automatic test_mid_frame();
    int w_cur, guard;
    run_until_flag(MAXP, 2000);
    guard = 0;
    while (cnt != 10 && guard < 200) begin
      cycle(cnt[2], MAXP);
      guard++;
    end
    w_cur = frame_w;
    checks++;
    if (pwm !== 1'b1 || w_cur !== MIN_P + MAXP) begin
      errors++;
      $display("FAIL mid_setup: pwm=%b width=%0d expected 1 %0d", pwm, w_cur, MIN_P + MAXP);
    end
    last_len = -1;
    while (cnt != 0) cycle(cnt[2], 0);
    cycle(cnt[2], 0);
    checks++;
    if (last_len !== w_cur) begin
      errors++;
      $display("FAIL mid_frame_width: got %0d expected %0d", last_len, w_cur);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    cycle(cnt[2], MAXP);
    while (!(pwm === 1'b1 && flag === 1'b0 && m_pos < MAXP - 6) && guard < 500) begin
      cycle(cnt[2], (cnt == 0) ? 0 : MAXP);
      guard++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm !== 1'b0 || flag !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pwm=%b flag=%b expected 0 0", pwm, flag);
    end
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, MAXP);
    rst_n = 1'b1;
    wait_two_frames(MAXP);
    checks++;
    if (last_len !== MIN_P + INITP) begin
      errors++;
      $display("FAIL reset_pos: got %0d expected %0d", last_len, MIN_P + INITP);
    end
  endtask

  task automatic test_tick_edge();
    for (int i = 0; i < 100; i++) cycle(1'b1, MAXP);
    wait_two_frames(MAXP);
    checks++;
    if (last_len !== MIN_P + INITP + STEPP) begin
      errors++;
      $display("FAIL hold_high: got %0d expected %0d", last_len, MIN_P + INITP + STEPP);
    end
    for (int i = 0; i < 20; i++) cycle((i % 2) == 0, MAXP);
    wait_two_frames(MAXP);
    checks++;
    if (last_len !== MIN_P + INITP + 11 * STEPP) begin
      errors++;
      $display("FAIL toggle: got %0d expected %0d", last_len, MIN_P + INITP + 11 * STEPP);
    end
  endtask

  task automatic test_overrange();
    int vals[4];
    vals[0] = 2000001; vals[1] = 3; vals[2] = 268435455; vals[3] = 100;
    frame_ok = 0;
    for (int i = 0; i < 4; i++) begin
      cnt = vals[i];
      cycle(1'b0, MAXP);
    end
    cnt = 1;
  endtask

  task automatic test_random();
    int d;
    bit s;
    d = MAXP / 2;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) d = $urandom_range(0, MAXP + 15);
      s = (i < 1200) ? cnt[2] : 1'($urandom_range(0, 1));
      cycle(s, d);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_clamp_and_reverse();
    test_random_targets();
    test_mid_frame();
    test_reset_mid();
    test_tick_edge();
    test_overrange();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/servo_ramp.md
Name: servo_ramp

Overview:
- Single-channel hobby-servo driver for the arm controller.
- Generates a PWM pulse whose width tracks an internal position register.
- The position register slews toward the commanded DESIRED position by one count per rising edge of a slow tick (SLK), which gives smooth arm motion.
- FLAG reports arrival at the commanded position; the arm sequencer debounces FLAG before advancing its state machine.

Parameters:
- MIN_PULSE, 50000, PWM high time in CLK cycles at position 0 (0.5 ms at 100 MHz).
- MAX_POS, 200000, upper clamp on position in counts; DESIRED above this is treated as MAX_POS.
- INIT_POS, 0, position value loaded on reset.
- STEP, 1, position increment/decrement per SLK rising edge.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RST_N  input  1  asynchronous active-low reset.
- SLK  input  1  slow tick level (parent drives COUNT[8]); sampled in the CLK domain.
- COUNT  input  28  shared free-running frame counter, 0..2000000 then wraps to 0 (20 ms frame).
- DESIRED  input  20  commanded position in counts, 0..MAX_POS.
- PWM  output  1  servo control pulse, registered.
- FLAG  output  1  high when position equals clamped DESIRED, registered.

Behaviour:
- Reset (RST_N low, asynchronous):
  - POS = INIT_POS; WIDTH = MIN_PULSE + INIT_POS; SLK_D = 0; PWM = 0; FLAG = 0.
  - Reset takes effect immediately mid-ramp or mid-pulse; a PWM pulse in progress is cut off.
- All other logic is synchronous to the CLK rising edge.
- SLK edge detect:
  - SLK_D <= SLK.
  - tick = SLK & ~SLK_D, one CLK cycle wide.
  - With SLK = COUNT[8], tick fires once every 512 CLK cycles.
- Target: TGT = min(DESIRED, MAX_POS), computed combinationally; DESIRED may change on any cycle.
- Slew, applied only on cycles where tick = 1:
  - POS < TGT: POS <= POS + min(STEP, TGT - POS).
  - POS > TGT: POS <= POS - min(STEP, POS - TGT).
  - POS == TGT: hold.
  - POS never overshoots TGT and never leaves 0..MAX_POS.
  - No wrap-around in either direction.
- Pulse width latch: when COUNT == 0, WIDTH <= MIN_PULSE + POS (21-bit sum). The width is therefore constant within a frame.
- PWM:
  - PWM <= (COUNT < WIDTH), unsigned, with WIDTH zero-extended to 28 bits.
  - One-cycle latency relative to COUNT.
  - The pulse starts the cycle after COUNT == 0 and is exactly WIDTH cycles long.
- FLAG:
  - FLAG <= (POS == TGT), one-cycle latency.
  - A DESIRED change drops FLAG on the next cycle if POS differs from the new TGT.
- Simultaneous events:
  - DESIRED changes on the same cycle as a tick: the slew uses the new TGT.
  - A tick and COUNT == 0 on the same cycle: WIDTH uses the pre-update POS.
- COUNT values above 2000000 are not expected; if they occur, PWM stays 0 whenever COUNT >= WIDTH.
- No handshake: DESIRED is level-sampled and FLAG is a status level.

Test Plan:
- Reset then idle: RST_N low, then high; DESIRED = 0, INIT_POS = 0 -> FLAG = 1 on the second CLK after release; each frame's PWM high for 50000 cycles.
- Ramp up: DESIRED = 31248 from POS = 0 -> POS increments once per 512 cycles; FLAG = 0 until POS = 31248 (~16.0M cycles), then FLAG = 1; next frame's PWM high for 81248 cycles.
- Ramp down with large command: POS = 31248, DESIRED = 250000 (clamped to 200000), then DESIRED = 113274 -> POS rises, reverses toward 113274 with no overshoot, settles; FLAG = 1 only at equality; PWM = 163274 cycles.
- Mid-frame change: DESIRED changed while COUNT = 1000 with a pulse in progress -> current frame's pulse width unchanged; new width appears only after the next COUNT == 0.
- Reset mid-operation: assert RST_N low during a ramp with PWM high -> PWM = 0 and FLAG = 0 immediately; POS returns to INIT_POS; the ramp restarts after release.
- Tick edge: hold SLK high for many cycles -> exactly one step; toggling SLK every cycle -> one step per rising edge.
